// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit and its neighbours
// (debug unit / run control, hazard unit, MEM-stage branch logic, ID stage).
// The master modport drives the i_* controls. The slave modport (the fetch unit)
// drives the o_* pipeline and status outputs.
interface instruction_fetch_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              i_start;
    logic              i_step_mode;
    logic              i_step;
    logic              i_clear;
    logic              i_PC_write;
    logic              i_branch_taken;
    logic [DATA_W-1:0] i_branch_addr;
    logic              i_imem_wr_en;
    logic [ADDR_W-1:0] i_imem_wr_addr;
    logic [DATA_W-1:0] i_imem_wr_data;
    logic [DATA_W-1:0] o_pc_plus4;
    logic [DATA_W-1:0] o_instr;
    logic              o_valid;
    logic [DATA_W-1:0] o_pc;
    logic [1:0]        o_state;
    logic              o_halted;
    logic [31:0]       o_fetch_count;

    modport master (
        output i_start, i_step_mode, i_step, i_clear, i_PC_write,
               i_branch_taken, i_branch_addr,
               i_imem_wr_en, i_imem_wr_addr, i_imem_wr_data,
        input  o_pc_plus4, o_instr, o_valid, o_pc, o_state, o_halted,
               o_fetch_count
    );

    modport slave (
        input  i_start, i_step_mode, i_step, i_clear, i_PC_write,
               i_branch_taken, i_branch_addr,
               i_imem_wr_en, i_imem_wr_addr, i_imem_wr_data,
        output o_pc_plus4, o_instr, o_valid, o_pc, o_state, o_halted,
               o_fetch_count
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage of the pipelined MIPS core: PC, debug-loadable instruction RAM,
// IF/ID pipeline register and run-control FSM.
// Optional feature macro: IF_PERF_CNT_EN enables the delivered-instruction counter
// on o_fetch_count. Without it o_fetch_count is tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for i_start; RAM writable; PC held; IF/ID = NOP
// RUN    | one fetch per cycle unless stalled or redirected
// STEP   | fetch only on an i_step pulse; bubble otherwise
// HALTED | HALT word fetched; RAM writable; i_clear returns to IDLE
module instruction_fetch_unit #(
    parameter int                 DATA_W     = 32,
    parameter int                 IMEM_DEPTH = 64,
    parameter logic [DATA_W-1:0]  HALT_INSTR = 32'hFFFF_FFFF,
    parameter int unsigned        PC_STEP    = 4
) (
    input logic                    clk,
    input logic                    rst,
    instruction_fetch_unit_if.slave bus
);
    localparam int ADDR_W = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ifid_pc4;
    logic [DATA_W-1:0] ifid_instr;
    logic              ifid_valid;

    logic [DATA_W-1:0] imem [IMEM_DEPTH];
    logic [ADDR_W-1:0] imem_idx;
    logic [DATA_W-1:0] fetch_word;
    logic [DATA_W-1:0] pc_inc;
    logic              fe;
    logic              imem_wr_ok;

    assign imem_idx   = pc[ADDR_W+1:2];
    assign fetch_word = imem[imem_idx];
    assign pc_inc     = pc + DATA_W'(PC_STEP);
    assign fe         = (state == S_RUN) || ((state == S_STEP) && bus.i_step);
    assign imem_wr_ok = (state == S_IDLE) || (state == S_HALTED);

    // Debug loader writes land only while fetch is stopped; RAM has no reset.
    always_ff @(posedge clk) begin
        if (bus.i_imem_wr_en && imem_wr_ok) begin
            imem[bus.i_imem_wr_addr] <= bus.i_imem_wr_data;
        end
    end

    // Run-control FSM with PC and IF/ID register; branch beats stall beats fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ifid_pc4   <= '0;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ifid_pc4   <= '0;
                    ifid_instr <= '0;
                    ifid_valid <= 1'b0;
                    if (bus.i_start) begin
                        state <= bus.i_step_mode ? S_STEP : S_RUN;
                    end
                end
                S_RUN, S_STEP: begin
                    if (bus.i_branch_taken) begin
                        pc         <= bus.i_branch_addr;
                        ifid_pc4   <= '0;
                        ifid_instr <= '0;
                        ifid_valid <= 1'b0;
                    end else if (!bus.i_PC_write) begin
                        // hazard stall: PC and IF/ID keep their contents
                    end else if (fe) begin
                        ifid_pc4   <= pc_inc;
                        ifid_instr <= fetch_word;
                        ifid_valid <= 1'b1;
                        pc         <= pc_inc;
                        // HALT itself still drains down the pipe as a valid word
                        if (fetch_word == HALT_INSTR) begin
                            state <= S_HALTED;
                        end
                    end else begin
                        // step mode without a pulse: insert a bubble, never re-issue
                        ifid_pc4   <= '0;
                        ifid_instr <= '0;
                        ifid_valid <= 1'b0;
                    end
                end
                S_HALTED: begin
                    ifid_pc4   <= '0;
                    ifid_instr <= '0;
                    ifid_valid <= 1'b0;
                    if (bus.i_clear) begin
                        state <= S_IDLE;
                        pc    <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        load_valid;
    logic [31:0] fetch_count;

    assign load_valid = fe && bus.i_PC_write && !bus.i_branch_taken;

    // Counts edges that load a valid word into IF/ID; cleared with the FSM on i_clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if ((state == S_HALTED) && bus.i_clear) begin
            fetch_count <= '0;
        end else if (load_valid) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign bus.o_fetch_count = fetch_count;
`else
    assign bus.o_fetch_count = 32'd0;
`endif

    assign bus.o_pc_plus4 = ifid_pc4;
    assign bus.o_instr    = ifid_instr;
    assign bus.o_valid    = ifid_valid;
    assign bus.o_pc       = pc;
    assign bus.o_state    = state;
    assign bus.o_halted   = (state == S_HALTED);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table-driven run/stall/branch/halt
// vectors through a scoreboard queue, plus hand-written reset and single-step sequences.
module tb_instruction_fetch_unit;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef IF_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        bit          st, md, stp, clr, pcw, br;
        logic [31:0] ba;
        bit          we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_instr, e_pc4;
        bit          e_val;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] instr, pc4;
        bit          val;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    instruction_fetch_unit_if #(.DATA_W(32), .ADDR_W(6)) bus();

    instruction_fetch_unit #(.DATA_W(32), .IMEM_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int i);
        return 32'h2108_0000 | 32'(i);
    endfunction

    function automatic vec_t mk(input bit st, md, stp, clr, pcw, br, input logic [31:0] ba,
                                input bit we, input logic [5:0] wa, input logic [31:0] wd,
                                input logic [31:0] ei, ep, input bit ev,
                                input logic [31:0] epc, input logic [1:0] es, input logic [31:0] ec);
        vec_t v;
        v.st = st; v.md = md; v.stp = stp; v.clr = clr; v.pcw = pcw; v.br = br; v.ba = ba;
        v.we = we; v.wa = wa; v.wd = wd;
        v.e_instr = ei; v.e_pc4 = ep; v.e_val = ev; v.e_pc = epc; v.e_st = es; v.e_cnt = ec;
        return v;
    endfunction

    task automatic cmp(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s got %h want %h", tag, f, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got none want entry", tag);
            return;
        end
        e = exp_q.pop_front();
        cmp(tag, "instr",  bus.o_instr, e.instr);
        cmp(tag, "pc4",    bus.o_pc_plus4, e.pc4);
        cmp(tag, "valid",  32'(bus.o_valid), 32'(e.val));
        cmp(tag, "pc",     bus.o_pc, e.pc);
        cmp(tag, "state",  32'(bus.o_state), 32'(e.st));
        cmp(tag, "halted", 32'(bus.o_halted), 32'(e.st == 2'd3));
        cmp(tag, "count",  bus.o_fetch_count, CNT_EN ? e.cnt : 32'd0);
    endtask

    task automatic push_exp(input logic [31:0] ei, ep, input bit ev, input logic [31:0] epc,
                            input logic [1:0] es, input logic [31:0] ec);
        exp_t e;
        e.instr = ei; e.pc4 = ep; e.val = ev; e.pc = epc; e.st = es; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    task automatic apply(input vec_t v, input string tag);
        bus.i_start        = v.st;
        bus.i_step_mode    = v.md;
        bus.i_step         = v.stp;
        bus.i_clear        = v.clr;
        bus.i_PC_write     = v.pcw;
        bus.i_branch_taken = v.br;
        bus.i_branch_addr  = v.ba;
        bus.i_imem_wr_en   = v.we;
        bus.i_imem_wr_addr = v.wa;
        bus.i_imem_wr_data = v.wd;
        push_exp(v.e_instr, v.e_pc4, v.e_val, v.e_pc, v.e_st, v.e_cnt);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    // shorthand for control-only cycles (no RAM write)
    task automatic cyc(input bit st, md, stp, clr, pcw, br, input logic [31:0] ba,
                       input logic [31:0] ei, ep, input bit ev, input logic [31:0] epc,
                       input logic [1:0] es, input logic [31:0] ec, input string tag);
        apply(mk(st, md, stp, clr, pcw, br, ba, 0, 0, 0, ei, ep, ev, epc, es, ec), tag);
    endtask

    initial begin
        int valid_seen;

        bus.i_start = 0; bus.i_step_mode = 0; bus.i_step = 0; bus.i_clear = 0;
        bus.i_PC_write = 1; bus.i_branch_taken = 0; bus.i_branch_addr = 0;
        bus.i_imem_wr_en = 0; bus.i_imem_wr_addr = 0; bus.i_imem_wr_data = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(0, 0, 0, 0, 0, 0);
        check_out("reset");

        // load program while IDLE: RAM[i] = w(i), RAM[4] = HALT
        for (int i = 0; i < 64; i++) begin
            bus.i_imem_wr_en   = 1'b1;
            bus.i_imem_wr_addr = 6'(i);
            bus.i_imem_wr_data = (i == 4) ? HALT : w(i);
            @(posedge clk);
            #1;
        end
        bus.i_imem_wr_en = 1'b0;

        //            st md sp cl pw br ba      we wa  wd        instr     pc4     v  pc      st cnt
        // continuous run into HALT at RAM[4]
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,     0, 0,  0,        0,        0,      0, 0,      1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(0),     4,      1, 4,      1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(1),     8,      1, 8,      1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(2),     12,     1, 12,     1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(3),     16,     1, 16,     1, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        HALT,     20,     1, 20,     3, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        0,        0,      0, 20,     3, 5));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,     0, 0,  0,        0,        0,      0, 20,     3, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     1, 4,  w(4),     0,        0,      0, 20,     3, 5));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,     0, 0,  0,        0,        0,      0, 0,      0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     1, 10, HALT,     0,        0,      0, 0,      0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0,     0, 0,  0,        0,        0,      0, 0,      0, 0));
        // stall at PC=8, branch under stall, halt-vs-branch, RUN write ignored, index wrap
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,     0, 0,  0,        0,        0,      0, 0,      1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(0),     4,      1, 4,      1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(1),     8,      1, 8,      1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0,  0,        w(1),     8,      1, 8,      1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0,  0,        w(1),     8,      1, 8,      1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(2),     12,     1, 12,     1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h20,  0, 0,  0,        0,        0,      0, 'h20,   1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(8),     'h24,   1, 'h24,   1, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(9),     'h28,   1, 'h28,   1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'hF8,  0, 0,  0,        0,        0,      0, 'hF8,   1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     1, 0,  'hDEADBEEF, w(62),  'hFC,   1, 'hFC,   1, 6));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(63),    'h100,  1, 'h100,  1, 7));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(0),     'h104,  1, 'h104,  1, 8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h10,  0, 0,  0,        0,        0,      0, 'h10,   1, 8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        w(4),     'h14,   1, 'h14,   1, 9));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h28,  0, 0,  0,        0,        0,      0, 'h28,   1, 9));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        HALT,     'h2C,   1, 'h2C,   3, 10));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,     0, 0,  0,        0,        0,      0, 'h2C,   3, 10));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,     0, 0,  0,        0,        0,      0, 0,      0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset in RUN at PC=0x10, RAM must survive
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "rst_start");
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, w(k), 32'(4 * (k + 1)), 1, 32'(4 * (k + 1)), 1, 32'(k + 1),
                $sformatf("rst_run%0d", k));
        end
        #3;
        rst = 1'b1;
        #1;
        push_exp(0, 0, 0, 0, 0, 0);
        check_out("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "rst_restart");
        cyc(0, 0, 0, 0, 1, 0, 0, w(0), 4, 1, 4, 1, 1, "rst_ram_kept");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single step: 3 pulses, 4 bubble cycles apart
        valid_seen = 0;
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, "step_start");
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0, 1, 0, 0, w(k), 32'(4 * (k + 1)), 1, 32'(4 * (k + 1)), 2, 32'(k + 1),
                $sformatf("step_pulse%0d", k));
            if (bus.o_valid) valid_seen++;
            for (int b = 0; b < 4; b++) begin
                cyc((b == 1), 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'(4 * (k + 1)), 2, 32'(k + 1),
                    $sformatf("step_bubble%0d_%0d", k, b));
                if (bus.o_valid) valid_seen++;
            end
        end
        cmp("step_total", "valid_count", 32'(valid_seen), 32'd3);
        cmp("step_total", "final_pc", bus.o_pc, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
